// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the oversampled SPI packet receiver.
`timescale 1ns/1ps

package spi_rx_pkg;

  // Receiver frame-level state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // SPI mode encodings as {CPOL,CPHA}
  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  // Start-of-frame marker sent by the Arduino
  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // Byte positions of the sensor fields inside a frame
  localparam int IDX_ROLL  = 1;
  localparam int IDX_PITCH = 3;
  localparam int IDX_YAW   = 5;
  localparam int IDX_GX    = 7;
  localparam int IDX_GY    = 9;
  localparam int IDX_GZ    = 11;
  localparam int IDX_FLAGS = 13;

  // Idle level of SCK for a given mode
  function automatic logic mode_cpol(input int mode);
    return (mode == SPI_MODE2) || (mode == SPI_MODE3);
  endfunction

  // Whether data is sampled on the second (trailing) SCK edge
  function automatic logic mode_cpha(input int mode);
    return (mode == SPI_MODE1) || (mode == SPI_MODE3);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for an asynchronous level, with one-cycle
// rise/fall pulses derived from the synchronised value.
`timescale 1ns/1ps

module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   hist_q;

  // Shift the raw input through the chain and remember the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], din};
      hist_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign dout = chain_q[SYNC_STAGES-1];
  assign rise = dout & ~hist_q;
  assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_packet_rx.sv
// Read-only SPI slave that oversamples SCK/CS_n/MOSI in the clk domain,
// assembles fixed-length frames, validates them and hands good ones to the
// MCU-side logic through a single-entry valid/ready register.
`timescale 1ns/1ps

module spi_packet_rx
  import spi_rx_pkg::*;
#(
  parameter int         PACKET_BYTES = 16,
  parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER,
  parameter int         SPI_MODE     = 0,
  parameter bit         MSB_FIRST    = 1'b1,
  parameter bit         CHECKSUM_EN  = 1'b1,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs_n,
  input  logic                      sck,
  input  logic                      sdi,
  output logic [8*PACKET_BYTES-1:0] pkt_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic                      initialized,
  output logic                      err_header,
  output logic                      err_length,
  output logic                      err_checksum,
  output logic                      err_drop,
  output logic [15:0]               pkt_count
);

  localparam bit CPOL        = mode_cpol(SPI_MODE);
  localparam bit CPHA        = mode_cpha(SPI_MODE);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  localparam int                 IDX_W   = $clog2(PACKET_BYTES + 1);
  localparam logic [IDX_W-1:0]   PKT_LEN = IDX_W'(PACKET_BYTES);
  localparam int                 FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_N = FLUSH_W'(SYNC_STAGES);

  // Synchronised views of the SPI pins
  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic sdi_s;
  logic sample_edge;

  // Frame assembly state
  rx_state_e          state_q, state_d;
  logic               start_frame;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q;
  logic [IDX_W-1:0]   byte_idx_q;
  logic               ovf_q;
  logic               bit_done;
  logic               buf_wr;
  logic [7:0]         rx_buf [PACKET_BYTES];

  // Reset arming: a frame may only start after CS_n has been seen high post-reset
  logic [FLUSH_W-1:0] flush_cnt_q;
  logic               cs_armed_q;

  // Frame evaluation
  logic [7:0] ck_xor;
  logic       in_check, len_ok, hdr_ok, ck_ok, frame_good, slot_free, commit;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (CPOL)
  ) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .dout  (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .dout  (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Plain synchroniser for MOSI, same depth as the SCK path so data lines up with the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_q <= '0;
    end else begin
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
    end
  end

  assign sdi_s       = sdi_q[SYNC_STAGES-1];
  assign sample_edge = (sck_rise | sck_fall) & (sck_level == SAMPLE_RISE);
  assign shift_d     = MSB_FIRST ? {shift_q[6:0], sdi_s} : {sdi_s, shift_q[7:1]};
  assign bit_done    = (bit_cnt_q == 3'd7);
  assign buf_wr      = (state_q == RECV) && sample_edge && bit_done && (byte_idx_q < PKT_LEN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_frame marks every entry into RECV
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && cs_armed_q) begin
          state_d     = RECV;
          start_frame = 1'b1;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!cs_level) begin
          state_d     = RECV;
          start_frame = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait for the synchroniser to flush its reset value, then arm once CS_n reads high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      cs_armed_q  <= 1'b0;
    end else begin
      if (flush_cnt_q != FLUSH_N) begin
        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
      end else if (cs_level) begin
        cs_armed_q <= 1'b1;
      end
    end
  end

  // Bit shifter and byte/bit counters, cleared at the start of every frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else if (start_frame) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else if ((state_q == RECV) && sample_edge) begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_done) begin
        if (byte_idx_q < PKT_LEN) begin
          byte_idx_q <= byte_idx_q + IDX_W'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Receive buffer; stale contents are harmless because short frames never commit
  always_ff @(posedge clk) begin
    for (int i = 0; i < PACKET_BYTES; i++) begin
      if (buf_wr && (byte_idx_q == IDX_W'(i))) begin
        rx_buf[i] <= shift_d;
      end
    end
  end

  // XOR of the payload bytes between header and checksum
  always_comb begin
    ck_xor = '0;
    for (int i = 1; i < PACKET_BYTES - 1; i++) begin
      ck_xor = ck_xor ^ rx_buf[i];
    end
  end

  assign in_check   = (state_q == CHECK);
  assign len_ok     = (byte_idx_q == PKT_LEN) && (bit_cnt_q == 3'd0) && !ovf_q;
  assign hdr_ok     = (rx_buf[0] == HEADER_BYTE);
  assign ck_ok      = !CHECKSUM_EN || (ck_xor == rx_buf[PACKET_BYTES-1]);
  assign frame_good = in_check && len_ok && hdr_ok && ck_ok;
  assign slot_free  = !pkt_valid || pkt_ready;
  assign commit     = frame_good && slot_free;

  // Output register: error pulses, frame commit and consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_data     <= '0;
      pkt_valid    <= 1'b0;
      pkt_count    <= '0;
      initialized  <= 1'b0;
      err_header   <= 1'b0;
      err_length   <= 1'b0;
      err_checksum <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      err_header   <= 1'b0;
      err_length   <= 1'b0;
      err_checksum <= 1'b0;
      err_drop     <= 1'b0;
      if (in_check) begin
        err_length   <= !len_ok;
        err_header   <= len_ok && !hdr_ok;
        err_checksum <= len_ok && hdr_ok && !ck_ok;
        err_drop     <= frame_good && !slot_free;
      end
      if (commit) begin
        for (int i = 0; i < PACKET_BYTES; i++) begin
          pkt_data[8*i +: 8] <= rx_buf[i];
        end
        pkt_valid   <= 1'b1;
        pkt_count   <= pkt_count + 16'd1;
        initialized <= 1'b1;
      end else if (pkt_valid && pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_rx.sv
// Scoreboard bench for spi_packet_rx: two instances (mode 0 MSB-first and
// mode 3 LSB-first) driven by directed frames; a monitor checks every
// commit and error pulse against the expected-event queue.
`timescale 1ns/1ps

module tb_spi_packet_rx;

  localparam int N        = 16;
  localparam int W        = 8 * N;
  localparam int CLK_NS   = 10;
  localparam int HALF_SCK = 5 * CLK_NS;

  localparam int K_COMMIT = 0;
  localparam int K_HDR    = 1;
  localparam int K_LEN    = 2;
  localparam int K_CK     = 3;
  localparam int K_DROP   = 4;

  typedef struct {
    int           dut;
    int           kind;
    logic [W-1:0] data;
    logic [15:0]  count;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs_n         [2];
  logic         sck          [2];
  logic         sdi          [2];
  logic         pkt_ready    [2];
  logic [W-1:0] pkt_data     [2];
  logic         pkt_valid    [2];
  logic         initialized  [2];
  logic         err_header   [2];
  logic         err_length   [2];
  logic         err_checksum [2];
  logic         err_drop     [2];
  logic [15:0]  pkt_count    [2];
  logic [15:0]  prev_count   [2];
  logic [7:0]   tx_bytes     [0:19];
  logic [W-1:0] frame1_data;
  logic [W-1:0] frame_a_data;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Free-running system clock
  always #(CLK_NS/2) clk = ~clk;

  spi_packet_rx #(
    .PACKET_BYTES (N),
    .HEADER_BYTE  (8'hAA),
    .SPI_MODE     (0),
    .MSB_FIRST    (1'b1),
    .CHECKSUM_EN  (1'b1),
    .SYNC_STAGES  (2)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_n         (cs_n[0]),
    .sck          (sck[0]),
    .sdi          (sdi[0]),
    .pkt_data     (pkt_data[0]),
    .pkt_valid    (pkt_valid[0]),
    .pkt_ready    (pkt_ready[0]),
    .initialized  (initialized[0]),
    .err_header   (err_header[0]),
    .err_length   (err_length[0]),
    .err_checksum (err_checksum[0]),
    .err_drop     (err_drop[0]),
    .pkt_count    (pkt_count[0])
  );

  spi_packet_rx #(
    .PACKET_BYTES (N),
    .HEADER_BYTE  (8'hAA),
    .SPI_MODE     (3),
    .MSB_FIRST    (1'b0),
    .CHECKSUM_EN  (1'b1),
    .SYNC_STAGES  (2)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_n         (cs_n[1]),
    .sck          (sck[1]),
    .sdi          (sdi[1]),
    .pkt_data     (pkt_data[1]),
    .pkt_valid    (pkt_valid[1]),
    .pkt_ready    (pkt_ready[1]),
    .initialized  (initialized[1]),
    .err_header   (err_header[1]),
    .err_length   (err_length[1]),
    .err_checksum (err_checksum[1]),
    .err_drop     (err_drop[1]),
    .pkt_count    (pkt_count[1])
  );

  // Single comparison primitive shared by the monitor and the directed checks
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected frame image built from the bytes the bench is about to send
  function automatic logic [W-1:0] frame_data();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[8*i +: 8] = tx_bytes[i];
    end
    return v;
  endfunction

  // Reference frame AA,01..0E with checksum 0F
  task automatic load_base();
    for (int i = 0; i < 20; i++) begin
      tx_bytes[i] = 8'h00;
    end
    tx_bytes[0] = 8'hAA;
    for (int i = 1; i < 15; i++) begin
      tx_bytes[i] = 8'(i);
    end
    tx_bytes[15] = 8'h0F;
  endtask

  task automatic push_expect(input int dut, input int kind, input logic [15:0] cnt);
    exp_t e;
    e.dut   = dut;
    e.kind  = kind;
    e.data  = frame_data();
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  // Serialise one byte; bus 0 is mode 0 MSB-first, bus 1 is mode 3 LSB-first
  task automatic spi_byte(input int idx, input logic [7:0] b);
    logic bitv;
    for (int k = 0; k < 8; k++) begin
      bitv = (idx == 0) ? b[7-k] : b[k];
      if (idx == 0) begin
        sdi[idx] = bitv;
        #HALF_SCK;
        sck[idx] = 1'b1;
        #HALF_SCK;
        sck[idx] = 1'b0;
      end else begin
        sck[idx] = 1'b0;
        sdi[idx] = bitv;
        #HALF_SCK;
        sck[idx] = 1'b1;
        #HALF_SCK;
      end
    end
  endtask

  // One complete CS-framed transfer of the first nbytes of tx_bytes
  task automatic applyStimulus(input int idx, input int nbytes, input int gap);
    @(negedge clk);
    cs_n[idx] = 1'b0;
    #HALF_SCK;
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(idx, tx_bytes[i]);
    end
    #HALF_SCK;
    cs_n[idx] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Pop the next expected event and compare it with what the DUT just produced
  task automatic score_event(input int d, input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_event dut=%0d actual_kind=%0d required=none", d, kind);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", W'(d * 8 + kind), W'(e.dut * 8 + e.kind));
      if ((e.dut == d) && (e.kind == kind) && (kind == K_COMMIT)) begin
        checkOutput("commit_data", pkt_data[d], e.data);
        checkOutput("commit_count", W'(pkt_count[d]), W'(e.count));
        checkOutput("commit_valid", W'(pkt_valid[d]), W'(1'b1));
        checkOutput("commit_init", W'(initialized[d]), W'(1'b1));
      end
    end
  endtask

  // Monitor: a commit shows as pkt_count stepping by one; errors as pulses
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pkt_count[d] == prev_count[d] + 16'd1) score_event(d, K_COMMIT);
      if (err_header[d])   score_event(d, K_HDR);
      if (err_length[d])   score_event(d, K_LEN);
      if (err_checksum[d]) score_event(d, K_CK);
      if (err_drop[d])     score_event(d, K_DROP);
      prev_count[d] = pkt_count[d];
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst_n         = 1'b0;
    cs_n[0]       = 1'b1;
    cs_n[1]       = 1'b1;
    sck[0]        = 1'b0;
    sck[1]        = 1'b1;
    sdi[0]        = 1'b0;
    sdi[1]        = 1'b0;
    pkt_ready[0]  = 1'b0;
    pkt_ready[1]  = 1'b0;
    prev_count[0] = 16'd0;
    prev_count[1] = 16'd0;
    load_base();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", W'(pkt_valid[0]), '0);
    checkOutput("rst_count", W'(pkt_count[0]), '0);
    checkOutput("rst_init", W'(initialized[0]), '0);
    checkOutput("rst_data", pkt_data[0], '0);
    checkOutput("rst_errs", W'({err_header[0], err_length[0], err_checksum[0], err_drop[0]}), '0);
    checkOutput("rst_count1", W'(pkt_count[1]), '0);
    repeat (5) @(negedge clk);

    $display("[TB] good frame, mode 0");
    pkt_ready[0] = 1'b1;
    frame1_data  = frame_data();
    push_expect(0, K_COMMIT, 16'd1);
    applyStimulus(0, 16, 20);
    checkOutput("t1_valid_popped", W'(pkt_valid[0]), '0);
    checkOutput("t1_init", W'(initialized[0]), W'(1'b1));
    checkOutput("t1_byte0", W'(pkt_data[0][7:0]), W'(8'hAA));
    checkOutput("t1_byte1", W'(pkt_data[0][15:8]), W'(8'h01));

    $display("[TB] bad header");
    tx_bytes[0] = 8'h55;
    push_expect(0, K_HDR, 16'd0);
    applyStimulus(0, 16, 20);
    tx_bytes[0] = 8'hAA;
    checkOutput("t2_count", W'(pkt_count[0]), W'(16'd1));
    checkOutput("t2_valid", W'(pkt_valid[0]), '0);

    $display("[TB] short and long frames");
    push_expect(0, K_LEN, 16'd0);
    applyStimulus(0, 10, 20);
    tx_bytes[16] = 8'h77;
    push_expect(0, K_LEN, 16'd0);
    applyStimulus(0, 17, 20);
    checkOutput("t3_data", pkt_data[0], frame1_data);
    checkOutput("t3_count", W'(pkt_count[0]), W'(16'd1));

    $display("[TB] back-to-back with consumer stalled");
    pkt_ready[0] = 1'b0;
    load_base();
    tx_bytes[1]  = 8'h11;
    tx_bytes[15] = 8'h1F;
    frame_a_data = frame_data();
    push_expect(0, K_COMMIT, 16'd2);
    applyStimulus(0, 16, 3);
    load_base();
    tx_bytes[2]  = 8'h22;
    tx_bytes[15] = 8'h2F;
    push_expect(0, K_DROP, 16'd0);
    applyStimulus(0, 16, 20);
    checkOutput("t4_valid_held", W'(pkt_valid[0]), W'(1'b1));
    checkOutput("t4_data_held", pkt_data[0], frame_a_data);
    pkt_ready[0] = 1'b1;
    @(negedge clk);
    checkOutput("t4_valid_fall", W'(pkt_valid[0]), '0);

    $display("[TB] mode 3 LSB-first checksum");
    pkt_ready[1] = 1'b1;
    load_base();
    tx_bytes[4] = 8'h44;
    push_expect(1, K_CK, 16'd0);
    applyStimulus(1, 16, 20);
    load_base();
    push_expect(1, K_COMMIT, 16'd1);
    applyStimulus(1, 16, 20);
    checkOutput("t5_byte2", W'(pkt_data[1][23:16]), W'(8'h02));

    $display("[TB] reset mid-frame");
    load_base();
    @(negedge clk);
    cs_n[0] = 1'b0;
    #HALF_SCK;
    for (int i = 0; i < 6; i++) begin
      spi_byte(0, tx_bytes[i]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_rst_count", W'(pkt_count[0]), '0);
    checkOutput("t6_rst_valid", W'(pkt_valid[0]), '0);
    rst_n = 1'b1;
    for (int i = 6; i < 16; i++) begin
      spi_byte(0, tx_bytes[i]);
    end
    #HALF_SCK;
    cs_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t6_no_commit", W'(pkt_count[0]), '0);
    push_expect(0, K_COMMIT, 16'd1);
    applyStimulus(0, 16, 20);

    repeat (10) @(negedge clk);
    checkOutput("pending_events", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_packet_rx.md
Name: spi_packet_rx

Overview:
- Parametrised, single-clock successor to the sensor-link SPI slave receiver; the FPGA remains a read-only slave to the Arduino master.
- SCK, CS_n and MOSI are oversampled into the `clk` domain, so no logic is clocked by SCK.
- Supports all four SPI modes, either bit order and any packet length, and validates each frame for length, header and XOR checksum.
- A validated frame is presented to the MCU-facing logic through a valid/ready output register.

Parameters:
- PACKET_BYTES, 16: bytes per frame (2..64).
- HEADER_BYTE, 8'hAA: required value of byte 0.
- SPI_MODE, 0: {CPOL,CPHA}, 0..3.
- MSB_FIRST, 1: 1 = bit 7 first, 0 = bit 0 first.
- CHECKSUM_EN, 1: 1 = last byte must equal the XOR of bytes 1..PACKET_BYTES-2.
- SYNC_STAGES, 2: synchroniser depth for sck/cs_n/sdi (≥2).

Ports:
- clk  in  1  system clock; must run at ≥8× SCK.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select from the Arduino, active low, asynchronous.
- sck  in  1  SPI clock, asynchronous.
- sdi  in  1  MOSI, asynchronous.
- pkt_data  out  8*PACKET_BYTES  committed frame; byte i sits in [8i+7:8i].
- pkt_valid  out  1  a committed frame is available.
- pkt_ready  in  1  consumer accepts the frame (the transfer happens when valid && ready).
- initialized  out  1  sticky; set by the first good frame.
- err_header / err_length / err_checksum / err_drop  out  1 each  one-cycle pulses.
- pkt_count  out  16  count of committed good frames; wraps.

Behaviour:
- Reset values:
  - Outputs: all outputs 0, including pkt_data.
  - Synchroniser flops: cs_n chain resets to 1, sck chain resets to CPOL, sdi chain resets to 0.
  - FSM: IDLE.
- Synchronisation and edge detect:
  - All three inputs pass through SYNC_STAGES flops, plus one history flop each for cs_n and sck.
  - The sample edge is sck rising when CPOL==CPHA, and sck falling otherwise. The sample edge is detected on the synchronised sck.
  - sdi is sampled from its synchroniser in the same cycle the edge is detected. All paths have equal depth.
- FSM states are IDLE, RECV and CHECK.
  - IDLE → RECV on a synchronised cs_n falling edge. On entry, byte_idx, bit_cnt and the shift register are cleared.
  - In RECV, each sample edge shifts in sdi.
    - MSB_FIRST: shift = {shift[6:0], sdi}.
    - Otherwise: shift = {sdi, shift[7:1]}.
  - On the 8th bit of a byte:
    - If byte_idx < PACKET_BYTES, the byte is written to rx_buf[byte_idx] and byte_idx increments.
    - Otherwise an overflow flag is set and byte_idx saturates.
  - RECV → CHECK on a synchronised cs_n rising edge.
  - In CHECK (exactly 1 cycle), the frame is evaluated:
    - len_ok: byte_idx==PACKET_BYTES, bit_cnt==0 and no overflow.
    - hdr_ok: rx_buf[0]==HEADER_BYTE.
    - ck_ok: !CHECKSUM_EN, or the XOR of rx_buf[1..N-2] equals rx_buf[N-1].
    - Error pulses: err_length if !len_ok. err_header if len_ok && !hdr_ok. err_checksum if len_ok && hdr_ok && !ck_ok. Exactly one error pulse fires per bad frame.
    - A good frame commits if the slot is free: pkt_valid==0, or pkt_ready==1 in this cycle (the pop and the push happen in the same cycle).
    - On commit, in the next cycle: pkt_data <= rx_buf, pkt_valid=1, pkt_count+1, initialized=1.
    - If the slot is not free, the good frame is discarded, err_drop pulses, and pkt_data is unchanged.
  - CHECK → RECV if synchronised cs_n is already low (back-to-back frame; counters are cleared). Otherwise CHECK → IDLE.
- Latency: pkt_valid rises 2 clk after the cycle in which the synchronised cs_n rising edge is detected.
- pkt_valid is cleared on valid && ready unless a new commit happens in the same cycle.
- pkt_data is stable while pkt_valid==1.
- rx_buf is never cleared; the frame-length check guarantees that stale bytes are never committed.
- A sample edge detected while in IDLE or CHECK is ignored.
- A partial frame in progress when rst_n deasserts is ignored: IDLE requires a fresh cs_n falling edge.
- A CS glitch shorter than SYNC_STAGES clk may be missed; this is specified as permissible.

Decomposition:
- Package spi_rx_pkg holds:
  - the state enum (IDLE, RECV, CHECK);
  - the SPI_MODE encodings;
  - the default HEADER_BYTE;
  - byte index constants for the sensor frame (ROLL=1, PITCH=3, YAW=5, GX=7, GY=9, GZ=11, FLAGS=13).
- One sub-module, spi_edge_sync, provides a SYNC_STAGES-deep synchroniser with rise/fall pulse outputs, parametrised by reset value. It is instantiated for sck and cs_n; sdi uses a plain chain.

Test Plan:
- Mode 0 MSB-first, sck=clk/10. Send frame AA,01,02,..,0E with byte 15 = XOR(bytes 1..14)=0x0F, pkt_ready=1 → pkt_valid pulses; pkt_data[7:0]=AA, pkt_data[15:8]=01; pkt_count=1; initialized=1; no error pulses.
- Frame with byte 0=0x55, otherwise valid → err_header pulses once; pkt_valid stays 0; pkt_count unchanged.
- CS_n rises after 10 bytes, then after 17 bytes → err_length pulses for each; pkt_data unchanged.
- Two good frames back-to-back, CS high for 4 clk, pkt_ready=0 → first committed; err_drop on the second; pkt_data still holds frame 1. Raise pkt_ready → pkt_valid falls next cycle.
- SPI_MODE=3, MSB_FIRST=0, CHECKSUM_EN=1, one byte corrupted → err_checksum; the corrected frame then commits with its bytes bit-order correct.
- Assert rst_n low mid-frame (byte 6), release while CS_n is still low, then finish the frame → no commit or error for the frame in which reset occurred. The next full frame commits with pkt_count=1.
